// File: rtl/spi_regbank_sync.sv
// SPI-slave register bank, fully in the clk domain with oversampled pins.
// Optional error counter at idx 62: define SPI_REGBANK_ERRCNT_EN.
module spi_regbank_sync #(
  parameter int NREG = 8,
  parameter int DW = 8,
  parameter logic [NREG*DW-1:0] RESET_VALS = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               spi_clk,
  input  logic               spi_cs_n,
  input  logic               spi_mosi,
  output logic               spi_miso,
  output logic [NREG*DW-1:0] regs,
  output logic               wr_stb,
  output logic [5:0]         wr_idx,
  output logic               frame_err
);

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, OVER, HOLD
  } state_t;

  localparam logic [4:0]  DWC = 5'(DW);
  localparam logic [15:0] KEY = 16'h00A5;

  state_t state, state_n;

  logic [2:0] sck_q;
  logic [2:0] csn_q;
  logic [1:0] mosi_q;
  logic [1:0] cs_raw;

  logic sck_rise, sck_fall;
  logic cs_rise, cs_fall;
  logic mosi_bit;

  logic [4:0]    cnt;
  logic [6:0]    hdr;
  logic [7:0]    hdr_full;
  logic [DW-1:0] dat;
  logic [DW-1:0] rb;
  logic [DW-1:0] rd;
  logic [1:0]    op;
  logic [5:0]    idx;
  logic          commit_q;

  logic take_hdr, take_dat, shift_rb;
  logic go_commit, go_err, clr_cnt;

  logic [DW-1:0] r [NREG];

`ifdef SPI_REGBANK_ERRCNT_EN
  logic [7:0] errcnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_q  <= '0;
      csn_q  <= '1;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], spi_clk};
      csn_q  <= {csn_q[1:0], spi_cs_n};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  // Unreset copy of cs_n: lets reset decide between IDLE and HOLD
  always_ff @(posedge clk) begin
    cs_raw <= {cs_raw[0], spi_cs_n};
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_rise  = csn_q[1] & ~csn_q[2];
  assign cs_fall  = ~csn_q[1] & csn_q[2];
  assign mosi_bit = mosi_q[1];
  assign hdr_full = {hdr, mosi_bit};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= cs_raw[1] ? IDLE : HOLD;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    take_hdr  = 1'b0;
    take_dat  = 1'b0;
    shift_rb  = 1'b0;
    go_commit = 1'b0;
    go_err    = 1'b0;
    clr_cnt   = 1'b0;
    if (cs_rise) begin
      state_n = IDLE;
      unique case (state)
        ADDR: go_err = 1'b1;
        DATA: begin
          if (cnt == DWC) go_commit = 1'b1;
          else            go_err    = 1'b1;
        end
        OVER: go_err = 1'b1;
        default: ;
      endcase
    end else begin
      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            state_n = ADDR;
            clr_cnt = 1'b1;
          end
        end
        ADDR: begin
          if (sck_rise) begin
            take_hdr = 1'b1;
            if (cnt == 5'd7) begin
              state_n = DATA;
              clr_cnt = 1'b1;
            end
          end
        end
        DATA: begin
          if (sck_rise) begin
            if (cnt == DWC) state_n  = OVER;
            else            take_dat = 1'b1;
          end
          // The fall right after the header keeps the first bit on the line
          if (sck_fall && cnt != 5'd0) shift_rb = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd = '0;
    for (int i = 0; i < NREG; i++) begin
      if (hdr_full[5:0] == 6'(i)) rd = r[i];
    end
`ifdef SPI_REGBANK_ERRCNT_EN
    if (hdr_full[5:0] == 6'd62) rd = DW'(errcnt);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      hdr      <= '0;
      dat      <= '0;
      rb       <= '0;
      op       <= '0;
      idx      <= '0;
      commit_q <= 1'b0;
    end else begin
      commit_q <= go_commit;
      if (clr_cnt)                  cnt <= '0;
      else if (take_hdr | take_dat) cnt <= cnt + 5'd1;
      if (take_hdr) begin
        hdr <= hdr_full[6:0];
        if (cnt == 5'd7) begin
          op  <= hdr_full[7:6];
          idx <= hdr_full[5:0];
          rb  <= rd;
        end
      end
      if (take_dat) dat <= {dat[DW-2:0], mosi_bit};
      if (shift_rb) rb  <= {rb[DW-2:0], 1'b0};
    end
  end

  function automatic logic [DW-1:0] apply_op(
    input logic [1:0]    o,
    input logic [DW-1:0] a,
    input logic [DW-1:0] b
  );
    logic [DW-1:0] y;
    unique case (o)
      2'b00:   y = b;
      2'b01:   y = a | b;
      2'b10:   y = a & ~b;
      default: y = a ^ b;
    endcase
    return y;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r[i] <= RESET_VALS[i*DW +: DW];
      wr_stb    <= 1'b0;
      wr_idx    <= '0;
      frame_err <= 1'b0;
`ifdef SPI_REGBANK_ERRCNT_EN
      errcnt    <= '0;
`endif
    end else begin
      wr_stb    <= 1'b0;
      frame_err <= go_err;
`ifdef SPI_REGBANK_ERRCNT_EN
      if (go_err && errcnt != 8'hFF) errcnt <= errcnt + 8'd1;
`endif
      if (commit_q) begin
        if (idx == 6'd63) begin
          if (op == 2'b00 && dat == KEY[DW-1:0]) begin
            for (int i = 0; i < NREG; i++) r[i] <= RESET_VALS[i*DW +: DW];
            wr_stb <= 1'b1;
            wr_idx <= 6'd63;
`ifdef SPI_REGBANK_ERRCNT_EN
            errcnt <= '0;
`endif
          end
`ifdef SPI_REGBANK_ERRCNT_EN
        end else if (idx == 6'd62) begin
          if (op == 2'b00) begin
            errcnt <= '0;
            wr_stb <= 1'b1;
            wr_idx <= 6'd62;
          end
`endif
        end else begin
          for (int i = 0; i < NREG; i++) begin
            if (idx == 6'(i)) begin
              r[i]   <= apply_op(op, r[i], dat);
              wr_stb <= 1'b1;
              wr_idx <= idx;
            end
          end
        end
      end
    end
  end

  always_comb begin
    regs = '0;
    for (int i = 0; i < NREG; i++) regs[i*DW +: DW] = r[i];
  end

  assign spi_miso = (state == DATA) ? rb[DW-1] : 1'b0;

endmodule

// File: tb/tb_spi_regbank_sync.sv
// Bench for spi_regbank_sync: vector table of frames plus corner sequences,
// with a scoreboard for wr_stb/wr_idx and frame_err pulses.
module tb_spi_regbank_sync;

  localparam int NREG = 8;
  localparam int DW = 8;
  localparam logic [63:0] RV = 64'h0000_0000_0033_5A00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_clk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic [63:0] regs;
  logic        wr_stb;
  logic [5:0]  wr_idx;
  logic        frame_err;

  spi_regbank_sync #(
    .NREG(NREG),
    .DW(DW),
    .RESET_VALS(RV)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .spi_clk(spi_clk),
    .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .regs(regs),
    .wr_stb(wr_stb),
    .wr_idx(wr_idx),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [5:0] exp_idx_q[$];
  int exp_err = 0;
  logic [63:0] exp_regs;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    wait_clk(4);
    m = spi_miso;
    spi_clk = 1'b1;
    wait_clk(4);
    spi_clk = 1'b0;
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_high();
    wait_clk(4);
    spi_cs_n = 1'b1;
    wait_clk(12);
  endtask

  task automatic frame(input int n, input logic [31:0] v,
                       output logic [31:0] mb);
    logic m;
    mb = '0;
    cs_low();
    for (int i = n - 1; i >= 0; i--) begin
      spi_bit(v[i], m);
      mb = {mb[30:0], m};
    end
    cs_high();
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (wr_stb) begin
        if (exp_idx_q.size() == 0) begin
          check("wr_stb_unexpected", 64'(wr_stb), 64'd0);
        end else begin
          check("wr_idx", 64'(wr_idx), 64'(exp_idx_q.pop_front()));
        end
      end
      if (frame_err) begin
        check("frame_err_expected", 64'(exp_err > 0), 64'd1);
        if (exp_err > 0) exp_err--;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] hdr;
    logic [7:0] dat;
    logic [7:0] rb;
    int         chk;
    logic [7:0] val;
    bit         commit;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [31:0] mb;
    logic m;
    logic [15:0] w;

    tbl[0] = '{8'h01, 8'h3C, 8'h5A, 1, 8'h3C, 1'b1};
    tbl[1] = '{8'h41, 8'h81, 8'h3C, 1, 8'hBD, 1'b1};
    tbl[2] = '{8'h81, 8'h81, 8'hBD, 1, 8'h3C, 1'b1};
    tbl[3] = '{8'hC1, 8'hFF, 8'h3C, 1, 8'hC3, 1'b1};
    tbl[4] = '{8'h05, 8'h77, 8'h00, 5, 8'h77, 1'b1};
    tbl[5] = '{8'h0A, 8'h11, 8'h00, 1, 8'hC3, 1'b0};
    tbl[6] = '{8'h7F, 8'hA5, 8'h00, 1, 8'hC3, 1'b0};
    tbl[7] = '{8'h45, 8'h00, 8'h77, 5, 8'h77, 1'b1};
    tbl[8] = '{8'h42, 8'h00, 8'h33, 2, 8'h33, 1'b1};

    rst_n    = 1'b0;
    spi_clk  = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    wait_clk(5);
    check("reset_regs", regs, RV);
    check("reset_miso", 64'(spi_miso), 64'd0);
    check("reset_wr_stb", 64'(wr_stb), 64'd0);
    check("reset_wr_idx", 64'(wr_idx), 64'd0);
    check("reset_frame_err", 64'(frame_err), 64'd0);
    rst_n = 1'b1;
    wait_clk(5);
    exp_regs = RV;

    for (int k = 0; k < 9; k++) begin
      if (tbl[k].commit) exp_idx_q.push_back(tbl[k].hdr[5:0]);
      frame(16, {16'h0, tbl[k].hdr, tbl[k].dat}, mb);
      check($sformatf("readback_%0d", k), 64'(mb[7:0]), 64'(tbl[k].rb));
      exp_regs[tbl[k].chk*8 +: 8] = tbl[k].val;
      check($sformatf("regs_%0d", k), regs, exp_regs);
    end

    exp_err++;
    frame(12, {20'h0, 8'h01, 4'hF}, mb);
    exp_err++;
    frame(17, {15'h0, 8'h01, 8'hFF, 1'b1}, mb);
    check("regs_after_errs", regs, exp_regs);
    check("errs_seen", 64'(exp_err), 64'd0);

    w = {8'h02, 8'hEE};
    cs_low();
    for (int i = 15; i >= 11; i--) spi_bit(w[i], m);
    rst_n = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(1);
    exp_regs = RV;
    check("midreset_regs", regs, exp_regs);
    check("midreset_miso", 64'(spi_miso), 64'd0);
    check("midreset_wr_stb", 64'(wr_stb), 64'd0);
    for (int i = 10; i >= 0; i--) spi_bit(w[i], m);
    cs_high();
    check("hold_regs", regs, exp_regs);

    exp_idx_q.push_back(6'd2);
    frame(16, {16'h0, 8'h02, 8'h99}, mb);
    check("post_hold_rb", 64'(mb[7:0]), 64'h33);
    exp_regs[23:16] = 8'h99;
    check("post_hold_regs", regs, exp_regs);

    exp_idx_q.push_back(6'd1);
    frame(16, {16'h0, 8'h01, 8'h12}, mb);
    exp_regs[15:8] = 8'h12;
    check("pre_soft_regs", regs, exp_regs);

    exp_idx_q.push_back(6'd63);
    frame(16, {16'h0, 8'h3F, 8'hA5}, mb);
    check("soft_reset_regs", regs, RV);

`ifdef SPI_REGBANK_ERRCNT_EN
    frame(16, {16'h0, 8'h7E, 8'h00}, mb);
    check("errcnt_after_soft", 64'(mb[7:0]), 64'h00);
`endif

    wait_clk(4);
    check("wr_queue_empty", 64'(exp_idx_q.size()), 64'd0);
    check("err_pending", 64'(exp_err), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
